// File: rtl/pea_pkg.sv
// -----------------------------------------------------------------------------
// pea_pkg
//   Shared parameters and types for the PE functional-unit multiplier.
//
//   Build option:
//     MAGE_MUL_HIGH_EN  defined   -> accumulator is 2*N_BITS wide and the full
//                                    product (low and high halves) is kept.
//                       undefined -> accumulator is N_BITS wide; only the low
//                                    half of the product is produced.
//
//   Contents:
//     N_BITS, N_MUL_RADIX, N_MUL_STAGE  datapath geometry
//     MUL_DIGIT_W                       bits of b retired per stage
//     ACC_W                             accumulator width (depends on build)
//     N_MUL_REG                         number of registered stage boundaries
//     mul_stage_t                       contents of one pipeline register
//     mul_mag()                         two's-complement magnitude helper
// -----------------------------------------------------------------------------
package pea_pkg;

    localparam int N_BITS      = 32;
    localparam int N_MUL_RADIX = 16;
    localparam int N_MUL_STAGE = 8;
    localparam int MUL_DIGIT_W = $clog2(N_MUL_RADIX);

`ifdef MAGE_MUL_HIGH_EN
    localparam int ACC_W = 2 * N_BITS;
`else
    localparam int ACC_W = N_BITS;
`endif

    // Stage 0 is combinational from the operands and the last stage is
    // combinational to the outputs, so only N_MUL_STAGE-1 boundaries register.
    localparam int N_MUL_REG = N_MUL_STAGE - 1;

    // One pipeline register. The magnitudes travel with the partial sum so
    // every stage sees the same operands the op was issued with.
    typedef struct packed {
        logic              valid;
        logic              neg;
        logic [N_BITS-1:0] a_m;
        logic [N_BITS-1:0] b_m;
        logic [ACC_W-1:0]  acc;
    } mul_stage_t;

    // Magnitude of a two's-complement value as an unsigned number. The most
    // negative value maps onto 2^(N_BITS-1), which still fits unsigned.
    function automatic logic [N_BITS-1:0] mul_mag(input logic [N_BITS-1:0] x);
        return x[N_BITS-1] ? (~x + N_BITS'(1)) : x;
    endfunction

endpackage : pea_pkg

// File: rtl/r_mul_stage.sv
// -----------------------------------------------------------------------------
// r_mul_stage
//   One combinational shift-add step of the multiplier. Adds the partial
//   product a * digit, weighted by the digit position, onto the running sum.
//
//   Parameters:
//     STAGE_IDX  position of the digit within b (0 = least significant)
//
//   Ports:
//     a_i      in   N_BITS       multiplicand magnitude
//     digit_i  in   MUL_DIGIT_W  digit of the multiplier magnitude
//     acc_i    in   ACC_W        running sum from the previous stage
//     acc_o    out  ACC_W        running sum including this digit
//
//   With a narrow accumulator (ACC_W == N_BITS) the partial product is
//   truncated to the low half before the add; the low half of the final sum
//   is unaffected because addition and shifting only propagate upward.
// -----------------------------------------------------------------------------
module r_mul_stage
    import pea_pkg::*;
#(
    parameter int STAGE_IDX = 0
) (
    input  logic [N_BITS-1:0]      a_i,
    input  logic [MUL_DIGIT_W-1:0] digit_i,
    input  logic [ACC_W-1:0]       acc_i,
    output logic [ACC_W-1:0]       acc_o
);

    localparam int SHIFT = STAGE_IDX * MUL_DIGIT_W;

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] digit_ext;
    logic [ACC_W-1:0] partial;

    assign a_ext     = ACC_W'(a_i);
    assign digit_ext = ACC_W'(digit_i);
    assign partial   = (a_ext * digit_ext) << SHIFT;
    assign acc_o     = acc_i + partial;

endmodule : r_mul_stage

// File: rtl/r_mul_pipe.sv
// -----------------------------------------------------------------------------
// r_mul_pipe
//   Pipelined signed integer multiplier for the PE functional unit. Operands
//   are reduced to magnitudes, each of N_MUL_STAGE stages retires one radix
//   digit of b by shift-add, and the sign is restored at the output.
//
//   Build option: MAGE_MUL_HIGH_EN adds p_hi_o and widens the accumulator so
//   the full 2*N_BITS product is available. Without it only p_o exists.
//
//   Ports:
//     clk_i        in   1       clock
//     rst_n_i      in   1       asynchronous active-low reset
//     pea_ready_i  in   1       global advance; 0 freezes every register
//     en_i         in   1       operands valid this cycle
//     a_i          in   N_BITS  signed multiplicand
//     b_i          in   N_BITS  signed multiplier
//     p_o          out  N_BITS  low half of the signed product
//     p_hi_o       out  N_BITS  high half of the product (MAGE_MUL_HIGH_EN)
//     valid_o      out  1       p_o / p_hi_o hold a valid result
//
//   Flow control: an operation is accepted in a cycle where en_i=1 and
//   pea_ready_i=1. Its result is presented with valid_o=1 after exactly
//   N_MUL_STAGE-1 advancing cycles and is consumed by the first cycle with
//   pea_ready_i=1 while valid_o=1. With pea_ready_i=0 nothing moves, en_i is
//   ignored and the outputs hold. There is no backpressure other than
//   pea_ready_i; throughput is one operation per advancing cycle.
//
//   Data registers advance regardless of valid, so bubbles carry don't-care
//   data; p_o / p_hi_o are meaningful only while valid_o=1.
// -----------------------------------------------------------------------------
module r_mul_pipe
    import pea_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              pea_ready_i,
    input  logic              en_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] b_i,
    output logic [N_BITS-1:0] p_o,
`ifdef MAGE_MUL_HIGH_EN
    output logic [N_BITS-1:0] p_hi_o,
`endif
    output logic              valid_o
);

    localparam int LAST = N_MUL_REG - 1;

    // ---------------------------------------------------------------------
    // Operand conditioning (combinational, feeds stage 0)
    // ---------------------------------------------------------------------
    logic [N_BITS-1:0] a_m0;
    logic [N_BITS-1:0] b_m0;
    logic              neg0;

    assign a_m0 = mul_mag(a_i);
    assign b_m0 = mul_mag(b_i);
    assign neg0 = a_i[N_BITS-1] ^ b_i[N_BITS-1];

    // ---------------------------------------------------------------------
    // Shift-add stages
    // ---------------------------------------------------------------------
    mul_stage_t       pipe_q    [N_MUL_REG];
    logic [ACC_W-1:0] stage_acc [N_MUL_STAGE];
    logic [ACC_W-1:0] acc_zero;

    assign acc_zero = '0;

    for (genvar k = 0; k < N_MUL_STAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            r_mul_stage #(
                .STAGE_IDX (0)
            ) u_stage (
                .a_i     (a_m0),
                .digit_i (b_m0[0 +: MUL_DIGIT_W]),
                .acc_i   (acc_zero),
                .acc_o   (stage_acc[0])
            );
        end else begin : g_rest
            r_mul_stage #(
                .STAGE_IDX (k)
            ) u_stage (
                .a_i     (pipe_q[k-1].a_m),
                .digit_i (pipe_q[k-1].b_m[k*MUL_DIGIT_W +: MUL_DIGIT_W]),
                .acc_i   (pipe_q[k-1].acc),
                .acc_o   (stage_acc[k])
            );
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline registers. Everything, valid included, moves only when
    // pea_ready_i=1; reset discards whatever is in flight.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_MUL_REG; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (pea_ready_i) begin
            pipe_q[0] <= '{valid: en_i,
                           neg:   neg0,
                           a_m:   a_m0,
                           b_m:   b_m0,
                           acc:   stage_acc[0]};
            for (int k = 1; k < N_MUL_REG; k++) begin
                pipe_q[k] <= '{valid: pipe_q[k-1].valid,
                               neg:   pipe_q[k-1].neg,
                               a_m:   pipe_q[k-1].a_m,
                               b_m:   pipe_q[k-1].b_m,
                               acc:   stage_acc[k]};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output: last stage sum with the sign restored. A zero magnitude sum
    // negates to zero, so zero operands need no special case, and a cleared
    // pipeline (neg=0, acc=0) drives zero outputs.
    // ---------------------------------------------------------------------
    logic [ACC_W-1:0] acc_last;
    logic [ACC_W-1:0] prod;

    assign acc_last = stage_acc[N_MUL_STAGE-1];
    assign prod     = pipe_q[LAST].neg ? (~acc_last + ACC_W'(1)) : acc_last;

    assign p_o     = prod[N_BITS-1:0];
    assign valid_o = pipe_q[LAST].valid;

`ifdef MAGE_MUL_HIGH_EN
    assign p_hi_o = prod[ACC_W-1:N_BITS];
`endif

    // The final stage only needs the top digit of b; the lower digits of the
    // forwarded magnitude have already been consumed upstream.
    logic unused_last_b_m;
    assign unused_last_b_m = ^pipe_q[LAST].b_m;

endmodule : r_mul_pipe

// File: tb/tb_r_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_r_mul_pipe
//   Self-checking bench for r_mul_pipe. Expected products are pushed onto a
//   queue when an operation is accepted and popped by a monitor whenever the
//   DUT presents a result that is consumed (valid_o=1 with pea_ready_i=1).
//   Directed steps cover reset, latency, sign/boundary operands, back-to-back
//   issue, stalls and asynchronous reset, followed by a short random mix.
// -----------------------------------------------------------------------------
module tb_r_mul_pipe;
    import pea_pkg::*;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              pea_ready;
    logic              en;
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] b;
    logic [N_BITS-1:0] p;
`ifdef MAGE_MUL_HIGH_EN
    logic [N_BITS-1:0] p_hi;
`endif
    logic              valid;

    always #5 clk = ~clk;

    r_mul_pipe u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pea_ready_i (pea_ready),
        .en_i        (en),
        .a_i         (a),
        .b_i         (b),
        .p_o         (p),
`ifdef MAGE_MUL_HIGH_EN
        .p_hi_o      (p_hi),
`endif
        .valid_o     (valid)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    logic [63:0] exp_q[$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_valid = 0;
    int          run_len = 0;
    int          max_run = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: full signed 64-bit product.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint pr;
        pr = longint'($signed(x)) * longint'($signed(y));
        return pr;
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: pop one expectation per consumed result
    // ---------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n && pea_ready && valid) begin
            logic [63:0] e;
            n_valid++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("p_o", {32'd0, p}, {32'd0, e[31:0]});
`ifdef MAGE_MUL_HIGH_EN
                check("p_hi_o", {32'd0, p_hi}, {32'd0, e[63:32]});
`endif
            end
        end else if (pea_ready) begin
            run_len = 0;
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_exp(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
        en = 1'b1;
        a  = x;
        b  = y;
        exp_q.push_back(e);
        tick();
        en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        issue_exp(x, y, model(x, y));
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int cnt;
        cnt = 1;
        while (!valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check(tag, 64'(cnt), 64'(exp_lat));
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] snap_p;
        logic        snap_v;

        rst_n     = 1'b0;
        pea_ready = 1'b1;
        en        = 1'b0;
        a         = '0;
        b         = '0;
        #2;
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_p", 64'(p), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // 1: latency and a negative result
        issue_exp(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_valid("t1_latency", 7);
        check("t1_p_o", 64'(p), 64'h0000_0000_FFFF_FFEB);
        drain("t1_drain");

        // 2/3: boundary and sign combinations, back-to-back
        issue_exp(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue_exp(32'h7FFF_FFFF, 32'd2,         64'h0000_0000_FFFF_FFFE);
        issue_exp(32'd0,         32'hFFFF_FFFB, 64'h0);
        issue_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
        issue_exp(32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
        issue_exp(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        issue_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        issue_exp(32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB);
        issue_exp(32'h1234_5678, 32'd0,         64'h0);
        drain("t23_drain");

        // 4: eight back-to-back ops, results 2,6,...,72 in consecutive cycles
        repeat (3) tick();
        max_run = 0;
        n_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            issue_exp(32'(i), 32'(i + 1), 64'(i * (i + 1)));
        end
        drain("t4_drain");
        tick();
        check("t4_run", 64'(max_run), 64'd8);
        check("t4_count", 64'(n_valid), 64'd8);

        // 5: stall with three ops in flight; en_i is ignored while stalled
        n_valid = 0;
        issue(32'd100, 32'hFFFF_FFFE);
        issue(32'hFFFF_FFF7, 32'hFFFF_FFF7);
        issue(32'd12345, 32'd1000);
        pea_ready = 1'b0;
        en        = 1'b1;
        a         = 32'hDEAD_BEEF;
        b         = 32'h0000_0005;
        snap_p    = p;
        snap_v    = valid;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("t5_stall_valid", 64'(valid), 64'(snap_v));
            check("t5_stall_p", 64'(p), 64'(snap_p));
        end
        en        = 1'b0;
        pea_ready = 1'b1;
        drain("t5_drain");
        tick();
        check("t5_count", 64'(n_valid), 64'd3);

        // 5b: stall while a result sits on the output
        issue(32'hFFFF_FF00, 32'd77);
        wait_valid("t5b_latency", 7);
        pea_ready = 1'b0;
        snap_p    = p;
        repeat (3) begin
            tick();
            check("t5b_hold_valid", 64'(valid), 64'd1);
            check("t5b_hold_p", 64'(p), 64'(snap_p));
        end
        pea_ready = 1'b1;
        drain("t5b_drain");

        // 6: asynchronous reset with four ops in flight
        issue(32'd11, 32'd13);
        issue(32'hFFFF_FFF0, 32'd5);
        issue(32'd9, 32'hFFFF_FFFF);
        issue(32'd1000, 32'd1000);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(valid), 64'd0);
        check("t6_rst_p", 64'(p), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        #3 rst_n = 1'b1;
        n_valid = 0;
        repeat (12) tick();
        check("t6_no_stale", 64'(n_valid), 64'd0);
        issue_exp(32'd3, 32'd4, 64'd12);
        wait_valid("t6_latency", 7);
        check("t6_p_o", 64'(p), 64'd12);
        drain("t6_drain");

        // Random mix with random stalls
        for (int r = 0; r < 60; r++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            pea_ready = ($urandom_range(0, 3) != 0);
            en        = $urandom_range(0, 1) == 1;
            a         = x;
            b         = y;
            if (pea_ready && en) exp_q.push_back(model(x, y));
            tick();
        end
        en        = 1'b0;
        pea_ready = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_r_mul_pipe
